// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int count_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Accumulator, shifting multiplicand/multiplier and product register.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_store,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_product;
    logic [PW-1:0]    w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_product  = r_product;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
            end else if (i_step) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            // Final step's contribution is folded in on the store edge.
            if (i_store) begin
                r_product <= w_acc_next;
            end
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier with start/done handshake.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = count_w(WIDTH);

    mult_state_t r_state;
    mult_state_t w_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_busy;
    logic          r_done;
    logic          w_load;
    logic          w_step;
    logic          w_store;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_store      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_count_next = '0;
                    w_next       = RUN;
                end
            end
            RUN: begin
                w_step       = 1'b1;
                w_count_next = r_count + 1'b1;
                if (r_count == CW'(WIDTH - 1)) begin
                    w_store = 1'b1;
                    w_next  = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_store  (w_store),
        .i_a      (a),
        .i_b      (b),
        .o_product(product)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
